// File: rtl/writeback_pipe_pkg.sv
// rtl/writeback_pipe_pkg.sv - shared constants for the writeback pipeline
package writeback_pipe_pkg;

  // Default register address width (32 architectural registers)
  localparam int AW_DEFAULT = 5;

  // Hard-wired zero register; writes to it are discarded
  localparam int X0_ADDR = 0;

  // Legal range for the number of pipeline stages
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 4;

endpackage

// File: rtl/wb_stage_reg.sv
// rtl/wb_stage_reg.sv - one writeback pipeline stage register with hold and kill
module wb_stage_reg #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             kill,
  input  logic             d_valid,
  input  logic             d_wen,
  input  logic [AW-1:0]    d_rd,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic             q_wen,
  output logic [AW-1:0]    q_rd,
  output logic [WIDTH-1:0] q_data
);

  // Kill only drops the valid bit (payload may go stale); kill beats hold, reset beats both
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_wen   <= 1'b0;
      q_rd    <= '0;
      q_data  <= '0;
    end else if (kill) begin
      q_valid <= 1'b0;
    end else if (!hold) begin
      q_valid <= d_valid;
      q_wen   <= d_wen;
      q_rd    <= d_rd;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/writeback_pipe.sv
// rtl/writeback_pipe.sv - execute-to-writeback pipeline with stall, flush and forwarding
module writeback_pipe
  import writeback_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = AW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             reg_wen,
  input  logic [AW-1:0]    wr_reg,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic             rs1_hit,
  output logic [WIDTH-1:0] rs1_data,
  output logic             rs2_hit,
  output logic [WIDTH-1:0] rs2_data,
  output logic             reg_wen_out,
  output logic [AW-1:0]    wr_reg_out,
  output logic [WIDTH-1:0] alu_result_out,
  output logic             busy
);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $fatal(1, "writeback_pipe: DEPTH must be within 1..4");
  end

  // Stage state; index 0 is the youngest
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] wen;
  logic [DEPTH-1:0] ew;
  logic [AW-1:0]    rd   [DEPTH];
  logic [WIDTH-1:0] data [DEPTH];

  // Stage inputs: stage 0 takes the execute result, later stages take their predecessor
  logic [DEPTH-1:0] d_v;
  logic [DEPTH-1:0] d_wen;
  logic [AW-1:0]    d_rd   [DEPTH];
  logic [WIDTH-1:0] d_data [DEPTH];

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign d_v[s]    = in_valid;
      assign d_wen[s]  = reg_wen;
      assign d_rd[s]   = wr_reg;
      assign d_data[s] = alu_result;
    end else begin : g_chain
      assign d_v[s]    = v[s-1];
      assign d_wen[s]  = wen[s-1];
      assign d_rd[s]   = rd[s-1];
      assign d_data[s] = data[s-1];
    end

    wb_stage_reg #(
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .hold    (stall),
      .kill    (flush),
      .d_valid (d_v[s]),
      .d_wen   (d_wen[s]),
      .d_rd    (d_rd[s]),
      .d_data  (d_data[s]),
      .q_valid (v[s]),
      .q_wen   (wen[s]),
      .q_rd    (rd[s]),
      .q_data  (data[s])
    );

    // A stage only really writes when valid, enabled and not targeting x0
    assign ew[s] = v[s] & wen[s] & (rd[s] != AW'(X0_ADDR));
  end

  // Forwarding priority chains: walk oldest to youngest so the youngest match ends up on top.
  // An x0 lookup never hits because ew already excludes rd == x0.
  logic [DEPTH:0]   hit1_c;
  logic [DEPTH:0]   hit2_c;
  logic [WIDTH-1:0] dat1_c [DEPTH+1];
  logic [WIDTH-1:0] dat2_c [DEPTH+1];

  assign hit1_c[DEPTH] = 1'b0;
  assign hit2_c[DEPTH] = 1'b0;
  assign dat1_c[DEPTH] = '0;
  assign dat2_c[DEPTH] = '0;

  for (genvar s = 0; s < DEPTH; s++) begin : g_fwd
    logic m1;
    logic m2;
    assign m1        = ew[s] & (rd[s] == rs1_addr);
    assign m2        = ew[s] & (rd[s] == rs2_addr);
    assign hit1_c[s] = m1 | hit1_c[s+1];
    assign hit2_c[s] = m2 | hit2_c[s+1];
    assign dat1_c[s] = m1 ? data[s] : dat1_c[s+1];
    assign dat2_c[s] = m2 ? data[s] : dat2_c[s+1];
  end

  assign rs1_hit  = hit1_c[0];
  assign rs1_data = dat1_c[0];
  assign rs2_hit  = hit2_c[0];
  assign rs2_data = dat2_c[0];

  // A held last stage must not strobe the register file on every stalled cycle
  assign reg_wen_out    = ew[DEPTH-1] & ~stall;
  assign wr_reg_out     = rd[DEPTH-1];
  assign alu_result_out = data[DEPTH-1];
  assign busy           = |v;

endmodule

// File: tb/tb_writeback_pipe.sv
// tb/tb_writeback_pipe.sv - self-checking bench for writeback_pipe
module tb_writeback_pipe;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic             reg_wen;
  logic [AW-1:0]    wr_reg;
  logic [WIDTH-1:0] alu_result;
  logic [AW-1:0]    rs1_addr;
  logic [AW-1:0]    rs2_addr;
  logic             rs1_hit;
  logic [WIDTH-1:0] rs1_data;
  logic             rs2_hit;
  logic [WIDTH-1:0] rs2_data;
  logic             reg_wen_out;
  logic [AW-1:0]    wr_reg_out;
  logic [WIDTH-1:0] alu_result_out;
  logic             busy;

  typedef struct {
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  writeback_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .in_valid       (in_valid),
    .reg_wen        (reg_wen),
    .wr_reg         (wr_reg),
    .alu_result     (alu_result),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_hit        (rs1_hit),
    .rs1_data       (rs1_data),
    .rs2_hit        (rs2_hit),
    .rs2_data       (rs2_data),
    .reg_wen_out    (reg_wen_out),
    .wr_reg_out     (wr_reg_out),
    .alu_result_out (alu_result_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction before the next edge; cyc+DEPTH is when it reaches the outputs
  task automatic drive(input logic v, input logic w, input logic [AW-1:0] r,
                       input logic [WIDTH-1:0] d, input bit expect_wr, input bit timed);
    exp_t e;
    in_valid   = v;
    reg_wen    = w;
    wr_reg     = r;
    alu_result = d;
    if (expect_wr) begin
      e.rd   = r;
      e.data = d;
      e.cyc  = timed ? cyc + DEPTH : -1;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    reg_wen    = 1'b0;
    wr_reg     = '0;
    alu_result = '0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reg_wen_out === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write cyc=%0d rd=%0d data=%h required=no write", cyc, wr_reg_out, alu_result_out);
        end else begin
          e = exp_q.pop_front();
          if (wr_reg_out !== e.rd || alu_result_out !== e.data) begin
            bad++;
            $display("FAIL write_payload rd=%0d data=%h required rd=%0d data=%h", wr_reg_out, alu_result_out, e.rd, e.data);
          end
          if (e.cyc >= 0) begin
            total++;
            if (cyc !== e.cyc) begin
              bad++;
              $display("FAIL write_timing cyc=%0d required=%0d", cyc, e.cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rs1_addr = 5'd9; rs2_addr = 5'd9;
    in_valid = 1'b1; reg_wen = 1'b1; wr_reg = 5'd9; alu_result = 32'h99;
    step();
    step();
    @(negedge clk);
    total++;
    if ({reg_wen_out, wr_reg_out, alu_result_out, busy, rs1_hit, rs1_data, rs2_hit, rs2_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs wen=%b rd=%0d data=%h busy=%b h1=%b d1=%h h2=%b d2=%h required all 0",
               reg_wen_out, wr_reg_out, alu_result_out, busy, rs1_hit, rs1_data, rs2_hit, rs2_data);
    end
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
    step();
    idle();
    repeat (DEPTH + 1) step();
  endtask

  task automatic test_latency();
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1);
    step();
    idle();
    @(negedge clk);
    total++;
    if (reg_wen_out !== 1'b0) begin
      bad++;
      $display("FAIL latency_early wen=%b required=0", reg_wen_out);
    end
    step();
    @(negedge clk);
    total++;
    if (reg_wen_out !== 1'b1 || wr_reg_out !== 5'd5 || alu_result_out !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL latency_out wen=%b rd=%0d data=%h required 1/5/deadbeef", reg_wen_out, wr_reg_out, alu_result_out);
    end
    step();
    @(negedge clk);
    total++;
    if (reg_wen_out !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL latency_late wen=%b busy=%b required 0/0", reg_wen_out, busy);
    end
    step();
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0);
    step();
    idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    @(negedge clk);
    total++;
    if (rs1_hit !== 1'b0 || rs1_data !== '0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL x0_lookup hit=%b data=%h busy=%b required 0/0/1", rs1_hit, rs1_data, busy);
    end
    repeat (DEPTH + 1) step();
  endtask

  task automatic test_fwd_priority();
    drive(1'b1, 1'b1, 5'd7, 32'h11, 1'b1, 1'b1);
    step();
    drive(1'b1, 1'b1, 5'd7, 32'h22, 1'b1, 1'b1);
    step();
    idle();
    rs1_addr = 5'd7; rs2_addr = 5'd8;
    @(negedge clk);
    total++;
    if (rs1_hit !== 1'b1 || rs1_data !== 32'h22 || rs2_hit !== 1'b0 || rs2_data !== '0) begin
      bad++;
      $display("FAIL fwd_youngest h1=%b d1=%h h2=%b d2=%h required 1/22/0/0", rs1_hit, rs1_data, rs2_hit, rs2_data);
    end
    step();
    @(negedge clk);
    total++;
    if (rs1_hit !== 1'b1 || rs1_data !== 32'h22) begin
      bad++;
      $display("FAIL fwd_last_stage h1=%b d1=%h required 1/22", rs1_hit, rs1_data);
    end
    repeat (DEPTH + 1) step();
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 5'd3, 32'hAA, 1'b1, 1'b0);
    step();
    idle();
    repeat (DEPTH - 1) step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (reg_wen_out !== 1'b0 || wr_reg_out !== 5'd3 || alu_result_out !== 32'hAA || busy !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold i=%0d wen=%b rd=%0d data=%h busy=%b required 0/3/aa/1",
                 i, reg_wen_out, wr_reg_out, alu_result_out, busy);
      end
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    total++;
    if (reg_wen_out !== 1'b1) begin
      bad++;
      $display("FAIL stall_release wen=%b required=1", reg_wen_out);
    end
    step();
    @(negedge clk);
    total++;
    if (reg_wen_out !== 1'b0) begin
      bad++;
      $display("FAIL stall_single_write wen=%b required=0", reg_wen_out);
    end
    step();
  endtask

  task automatic test_flush_stall();
    drive(1'b1, 1'b1, 5'd10, 32'h55, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 5'd11, 32'h66, 1'b0, 1'b0);
    step();
    idle();
    stall = 1'b1; flush = 1'b1;
    rs1_addr = 5'd10; rs2_addr = 5'd11;
    step();
    stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || rs1_hit !== 1'b0 || rs2_hit !== 1'b0 || reg_wen_out !== 1'b0) begin
      bad++;
      $display("FAIL flush_kill busy=%b h1=%b h2=%b wen=%b required all 0", busy, rs1_hit, rs2_hit, reg_wen_out);
    end
    drive(1'b1, 1'b1, 5'd12, 32'h77, 1'b1, 1'b1);
    step();
    idle();
    rs1_addr = 5'd12;
    @(negedge clk);
    total++;
    if (rs1_hit !== 1'b1 || rs1_data !== 32'h77) begin
      bad++;
      $display("FAIL flush_recover h1=%b d1=%h required 1/77", rs1_hit, rs1_data);
    end
    repeat (DEPTH + 1) step();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, AW'(i), $urandom, 1'b1, 1'b1);
      step();
    end
    idle();
    repeat (DEPTH + 2) step();
  endtask

  initial begin
    idle();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_latency();
    test_x0();
    test_fwd_priority();
    test_stall();
    test_flush_stall();
    test_back_to_back();
    repeat (3) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
